semi_auto_nav: RTL and testbench
================================

Name: semi_auto_nav

Overview:
Parametrised successor to the single-step semi-automatic driving controller, sitting beside the manual and auto controllers under the top-level mode mux. Owns its state register, tick generator and a command queue, so the driver can pre-enter several crossroad decisions before reaching them. Generalises detector width, turn/reverse/cooldown durations and tick period, and adds a reverse manoeuvre, command queueing and overflow reporting.

Parameters:
DET_W, 4, detector width (>=3); bit 0 = front, bits DET_W-2..1 = side, bit DET_W-1 = rear (ignored)
TICK_DIV, 2000000, sys_clk cycles per control tick (20 ms at 100 MHz)
TURN_TICKS, 200, ticks spent turning left/right
BACK_TICKS, 400, ticks spent in the reverse (spin-right) manoeuvre
COOL_TICKS, 10, ticks of forward motion with crossroad detection masked
QDEPTH, 4, command queue depth (power of 2, >=2)
CNT_W, 11, duration counter width; every *_TICKS must be < 2^CNT_W

Ports:
sys_clk  in  1  system clock
rst  in  1  asynchronous active-low reset
power  in  1  vehicle power
global_state  in  2  top mode; block enabled only for 2'b01 or 2'b10
detector  in  DET_W  line/obstacle sensors
turn_left, turn_right, go_straight, go_back  in  1 each  driver buttons (level)
moving_state  out  4  0001 forward, 0000 stop, 0100 left, 1000 right
nav_state  out  3  current FSM state code
move_forward_light, move_backward_light, turn_left_light, turn_right_light  out  1 each  lamps
q_count  out  $clog2(QDEPTH)+1  queued commands
q_full  out  1  queue full
cmd_drop  out  1  one-cycle pulse on a rejected command

Behaviour:
- Reset (rst=0, async): state IDLE, all outputs 0, queue empty, tick and duration counters 0.
- enable = power & (global_state==01 | global_state==10). enable=0 in any state -> IDLE next cycle; moving_state 0000; counters cleared; queue flushed.
- crossroad = detector[0] | ~&detector[DET_W-2:1], evaluated every sys_clk.
- Tick: free-running counter 0..TICK_DIV-1; tick is a one-cycle pulse at wrap. Cleared in IDLE.
- Command: the 4-bit button vector registered once; a command is accepted on the cycle it changes to exactly one-hot from any other value. Codes: 00 straight, 01 right, 10 left, 11 back. Non-one-hot vectors are ignored.
- Push: an accepted command is pushed if enable=1. Queue full and no pop in the same cycle -> drop, cmd_drop=1 for one cycle, queue unchanged. Full with a simultaneous pop -> push accepted.
- States (codes 0-4): IDLE, FWD, WAIT, TURN, COOL. All outputs registered; they change in the cycle after the transition.
  IDLE: enable=1 -> WAIT, stop.
  FWD: moving 0001; crossroad=1 -> WAIT, stop.
  WAIT: moving 0000. If the queue is non-empty, pop the head; if empty but a command is accepted this cycle, use it directly (bypass, not queued). Straight -> COOL; left/right/back -> TURN with dir latched.
  TURN: left -> 0100; right or back -> 1000. dur increments on tick; on the tick where dur==LIMIT-1 (LIMIT=TURN_TICKS, or BACK_TICKS for back) -> COOL, dur=0. Residency is exactly LIMIT ticks, within +1 tick of phase.
  COOL: moving 0001; crossroad ignored; after COOL_TICKS ticks -> FWD.
- Lamps: forward=moving 0001; left=TURN&left; right=TURN&(right|back); backward=TURN&back; otherwise 0.
- The queue is never popped outside WAIT. Queued commands persist across FWD/TURN/COOL.
- Counters saturate-free: the limits guarantee no wrap. Reset mid-TURN returns to IDLE immediately.

Decomposition:
- Package semi_nav_pkg: state codes (IDLE..COOL), moving codes (MV_FWD, MV_STOP, MV_LEFT, MV_RIGHT), command codes (CMD_STRAIGHT..CMD_BACK).
- Sub-module nav_cmd_fifo: synchronous FIFO with parameters QDEPTH and width 2, ports push/pop/flush/din/dout/count/full/empty, same clock and reset. The tick generator and FSM live in semi_auto_nav.

Test Plan:
Benches use TICK_DIV=4, TURN_TICKS=3, BACK_TICKS=6, COOL_TICKS=2, QDEPTH=2.
- Reset: rst low mid-TURN -> all outputs 0 asynchronously; after release with enable -> WAIT, moving 0000.
- Bypass left: WAIT, queue empty, turn_left rises -> TURN, moving 0100, turn_left_light=1 for 3 ticks; then COOL 0001 for 2 ticks; then FWD.
- Queue: in FWD, press right then straight -> q_count=2, q_full=1. A third press -> cmd_drop pulse, q_count stays 2. detector=4'b0001 -> WAIT pops right; TURN moving 1000.
- Back: WAIT with back queued -> moving 1000 and move_backward_light=1 for 6 ticks, then COOL.
- Crossroad masked: in COOL, detector[0]=1 -> remains COOL for 2 ticks, then FWD -> WAIT on the next cycle.
- Disable: global_state=00 while q_count=1 in TURN -> IDLE, moving 0000, q_count=0. Two simultaneous buttons -> no push.

Source files
------------

// File: rtl/semi_nav_pkg.sv
// Shared codes for the semi-automatic navigation controller: FSM states,
// wheel/moving patterns and driver command encodings.
package semi_nav_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_FWD  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_TURN = 3'd3;
    localparam logic [2:0] ST_COOL = 3'd4;

    localparam logic [3:0] MV_FWD   = 4'b0001;
    localparam logic [3:0] MV_STOP  = 4'b0000;
    localparam logic [3:0] MV_LEFT  = 4'b0100;
    localparam logic [3:0] MV_RIGHT = 4'b1000;

    localparam logic [1:0] CMD_STRAIGHT = 2'b00;
    localparam logic [1:0] CMD_RIGHT    = 2'b01;
    localparam logic [1:0] CMD_LEFT     = 2'b10;
    localparam logic [1:0] CMD_BACK     = 2'b11;

    typedef struct packed {
        logic fwd;
        logic back;
        logic left;
        logic right;
    } lamps_t;

    // Button vector is {back, left, right, straight}; only valid for one-hot input.
    function automatic logic [1:0] btn2cmd(input logic [3:0] b);
        return {b[3] | b[2], b[3] | b[1]};
    endfunction

endpackage

// File: rtl/nav_cmd_fifo.sv
// Small synchronous command FIFO; a push while full is only taken when a pop
// frees a slot in the same cycle.
module nav_cmd_fifo #(
    parameter int QDEPTH = 4,
    parameter int W      = 2
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(QDEPTH):0]  count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(QDEPTH);

    logic [W-1:0]  r_mem [QDEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;
    logic          w_wr;
    logic          w_rd;

    assign empty = (r_cnt == '0);
    assign full  = (r_cnt == (AW+1)'(QDEPTH));
    assign count = r_cnt;
    assign dout  = r_mem[r_rp];
    assign w_rd  = pop && !empty;
    assign w_wr  = push && (!full || w_rd);

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else if (flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr) r_wp <= r_wp + 1'b1;
            if (w_rd) r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_wr && !flush) r_mem[r_wp] <= din;
    end

endmodule

// File: rtl/semi_auto_nav.sv
// Semi-automatic driving controller: follows the line, stops at crossroads and
// executes queued (or freshly pressed) driver decisions with timed manoeuvres.
module semi_auto_nav
    import semi_nav_pkg::*;
#(
    parameter int DET_W      = 4,
    parameter int TICK_DIV   = 2000000,
    parameter int TURN_TICKS = 200,
    parameter int BACK_TICKS = 400,
    parameter int COOL_TICKS = 10,
    parameter int QDEPTH     = 4,
    parameter int CNT_W      = 11
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic                     power,
    input  logic [1:0]               global_state,
    input  logic [DET_W-1:0]         detector,
    input  logic                     turn_left,
    input  logic                     turn_right,
    input  logic                     go_straight,
    input  logic                     go_back,
    output logic [3:0]               moving_state,
    output logic [2:0]               nav_state,
    output logic                     move_forward_light,
    output logic                     move_backward_light,
    output logic                     turn_left_light,
    output logic                     turn_right_light,
    output logic [$clog2(QDEPTH):0]  q_count,
    output logic                     q_full,
    output logic                     cmd_drop
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]    TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] TURN_LIM = CNT_W'(TURN_TICKS - 1);
    localparam logic [CNT_W-1:0] BACK_LIM = CNT_W'(BACK_TICKS - 1);
    localparam logic [CNT_W-1:0] COOL_LIM = CNT_W'(COOL_TICKS - 1);

    logic [2:0]       r_state;
    logic [1:0]       r_dir;
    logic [CNT_W-1:0] r_dur;
    logic [TW-1:0]    r_tick_cnt;
    logic [3:0]       r_btn;
    logic [3:0]       r_btn_d;

    logic             w_en;
    logic             w_cross;
    logic             w_tick;
    logic             w_acc;
    logic [1:0]       w_cmd;
    logic [2:0]       w_ns;
    logic [1:0]       w_dir_nx;
    logic [CNT_W-1:0] w_dur_nx;
    logic [CNT_W-1:0] w_lim;
    logic             w_pop;
    logic             w_bypass;
    logic             w_go;
    logic [1:0]       w_sel;
    logic             w_push_req;
    logic             w_push;
    logic             w_drop;
    logic [3:0]       w_mv_nx;
    lamps_t           w_lamp_nx;
    logic [1:0]       w_q_dout;
    logic             w_q_empty;
    logic             w_unused_rear;

    assign w_en    = power && (global_state == 2'b01 || global_state == 2'b10);
    assign w_cross = detector[0] | ~&detector[DET_W-2:1];
    assign w_unused_rear = detector[DET_W-1];
    assign w_tick  = (r_state != ST_IDLE) && (r_tick_cnt == TICK_MAX);

    // A command is an edge into a one-hot button pattern, not a held level.
    assign w_acc = $onehot(r_btn) && (r_btn != r_btn_d);
    assign w_cmd = btn2cmd(r_btn);
    assign w_lim = (r_dir == CMD_BACK) ? BACK_LIM : TURN_LIM;

    always_comb begin
        w_ns     = r_state;
        w_dir_nx = r_dir;
        w_dur_nx = r_dur;
        w_pop    = 1'b0;
        w_bypass = 1'b0;
        w_go     = 1'b0;
        w_sel    = CMD_STRAIGHT;
        if (!w_en) begin
            w_ns     = ST_IDLE;
            w_dur_nx = '0;
        end else begin
            case (r_state)
                ST_IDLE: w_ns = ST_WAIT;
                ST_FWD:  if (w_cross) w_ns = ST_WAIT;
                ST_WAIT: begin
                    if (!w_q_empty) begin
                        w_pop = 1'b1;
                        w_go  = 1'b1;
                        w_sel = w_q_dout;
                    end else if (w_acc) begin
                        w_bypass = 1'b1;
                        w_go     = 1'b1;
                        w_sel    = w_cmd;
                    end
                    if (w_go) begin
                        w_dur_nx = '0;
                        if (w_sel == CMD_STRAIGHT) begin
                            w_ns = ST_COOL;
                        end else begin
                            w_ns     = ST_TURN;
                            w_dir_nx = w_sel;
                        end
                    end
                end
                ST_TURN: if (w_tick) begin
                    if (r_dur == w_lim) begin
                        w_ns     = ST_COOL;
                        w_dur_nx = '0;
                    end else begin
                        w_dur_nx = r_dur + 1'b1;
                    end
                end
                ST_COOL: if (w_tick) begin
                    if (r_dur == COOL_LIM) begin
                        w_ns     = ST_FWD;
                        w_dur_nx = '0;
                    end else begin
                        w_dur_nx = r_dur + 1'b1;
                    end
                end
                default: w_ns = ST_IDLE;
            endcase
        end
    end

    assign w_push_req = w_acc && w_en && !w_bypass;
    assign w_drop     = w_push_req && q_full && !w_pop;
    assign w_push     = w_push_req && !w_drop;

    nav_cmd_fifo #(.QDEPTH(QDEPTH), .W(2)) u_fifo (
        .sys_clk (sys_clk),
        .rst     (rst),
        .push    (w_push),
        .pop     (w_pop),
        .flush   (!w_en),
        .din     (w_cmd),
        .dout    (w_q_dout),
        .count   (q_count),
        .full    (q_full),
        .empty   (w_q_empty)
    );

    // Outputs are decoded from the next state so they register with it.
    always_comb begin
        w_mv_nx   = MV_STOP;
        w_lamp_nx = '0;
        case (w_ns)
            ST_FWD, ST_COOL: w_mv_nx = MV_FWD;
            ST_TURN: begin
                w_mv_nx         = (w_dir_nx == CMD_LEFT) ? MV_LEFT : MV_RIGHT;
                w_lamp_nx.left  = (w_dir_nx == CMD_LEFT);
                w_lamp_nx.right = (w_dir_nx == CMD_RIGHT) || (w_dir_nx == CMD_BACK);
                w_lamp_nx.back  = (w_dir_nx == CMD_BACK);
            end
            default: w_mv_nx = MV_STOP;
        endcase
        w_lamp_nx.fwd = (w_mv_nx == MV_FWD);
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_state             <= ST_IDLE;
            r_dir               <= CMD_STRAIGHT;
            r_dur               <= '0;
            r_tick_cnt          <= '0;
            r_btn               <= '0;
            r_btn_d             <= '0;
            nav_state           <= ST_IDLE;
            moving_state        <= MV_STOP;
            move_forward_light  <= 1'b0;
            move_backward_light <= 1'b0;
            turn_left_light     <= 1'b0;
            turn_right_light    <= 1'b0;
            cmd_drop            <= 1'b0;
        end else begin
            r_btn_d <= r_btn;
            r_btn   <= {go_back, turn_left, turn_right, go_straight};
            r_state <= w_ns;
            r_dir   <= w_dir_nx;
            r_dur   <= w_dur_nx;
            if (!w_en || r_state == ST_IDLE || w_tick) r_tick_cnt <= '0;
            else                                       r_tick_cnt <= r_tick_cnt + 1'b1;
            nav_state           <= w_ns;
            moving_state        <= w_mv_nx;
            move_forward_light  <= w_lamp_nx.fwd;
            move_backward_light <= w_lamp_nx.back;
            turn_left_light     <= w_lamp_nx.left;
            turn_right_light    <= w_lamp_nx.right;
            cmd_drop            <= w_drop;
        end
    end

endmodule

// File: tb/tb_semi_auto_nav.sv
// Randomised plus directed bench for semi_auto_nav against a queue-based
// behavioural model of the navigation rules.
module tb_semi_auto_nav;

    localparam int TD = 4, TT = 3, BT = 6, CT = 2, QD = 2;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b1;
    logic       power = 1'b0;
    logic [1:0] global_state = 2'b00;
    logic [3:0] detector = 4'b0110;
    logic       turn_left = 1'b0, turn_right = 1'b0, go_straight = 1'b0, go_back = 1'b0;
    logic [3:0] moving_state;
    logic [2:0] nav_state;
    logic       move_forward_light, move_backward_light, turn_left_light, turn_right_light;
    logic [1:0] q_count;
    logic       q_full, cmd_drop;

    int total = 0, bad = 0, drops = 0;

    semi_auto_nav #(
        .DET_W(4), .TICK_DIV(TD), .TURN_TICKS(TT), .BACK_TICKS(BT),
        .COOL_TICKS(CT), .QDEPTH(QD), .CNT_W(11)
    ) dut (
        .sys_clk(sys_clk), .rst(rst), .power(power), .global_state(global_state),
        .detector(detector), .turn_left(turn_left), .turn_right(turn_right),
        .go_straight(go_straight), .go_back(go_back), .moving_state(moving_state),
        .nav_state(nav_state), .move_forward_light(move_forward_light),
        .move_backward_light(move_backward_light), .turn_left_light(turn_left_light),
        .turn_right_light(turn_right_light), .q_count(q_count), .q_full(q_full),
        .cmd_drop(cmd_drop)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // States: 0 idle, 1 forward, 2 waiting at crossroad, 3 turning, 4 cooldown.
    int   m_st = 0, m_dir = 0, m_ticks = 0, m_phase = 0;
    bit   m_drop = 0;
    bit [3:0] m_b1 = 0, m_b2 = 0;
    int   mq[$];
    bit   m_en, m_acc, m_tick, m_pop, m_byp, m_cross;
    int   m_cmd, m_go;

    always @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            m_st = 0; m_dir = 0; m_ticks = 0; m_phase = 0; m_drop = 0;
            m_b1 = 0; m_b2 = 0; mq.delete();
        end else begin
            m_en  = power && (global_state == 2'b01 || global_state == 2'b10);
            m_acc = ($countones(m_b1) == 1) && (m_b1 != m_b2);
            m_cmd = m_b1[3] ? 3 : m_b1[2] ? 2 : m_b1[1] ? 1 : 0;
            m_b2  = m_b1;
            m_b1  = {go_back, turn_left, turn_right, go_straight};
            m_drop = 0;
            if (!m_en) begin
                m_st = 0; mq.delete(); m_phase = 0; m_ticks = 0;
            end else begin
                m_tick  = (m_st != 0) && (m_phase == TD - 1);
                m_phase = (m_st == 0 || m_tick) ? 0 : m_phase + 1;
                m_cross = detector[0] || (detector[2:1] != 2'b11);
                m_pop = 0; m_byp = 0; m_go = -1;
                case (m_st)
                    0: m_st = 2;
                    1: if (m_cross) m_st = 2;
                    2: begin
                        if (mq.size() > 0) begin m_go = mq.pop_front(); m_pop = 1; end
                        else if (m_acc) begin m_go = m_cmd; m_byp = 1; end
                        if (m_go == 0) begin m_st = 4; m_ticks = 0; end
                        else if (m_go > 0) begin m_st = 3; m_dir = m_go; m_ticks = 0; end
                    end
                    3: if (m_tick) begin
                        m_ticks++;
                        if (m_ticks == ((m_dir == 3) ? BT : TT)) begin m_st = 4; m_ticks = 0; end
                    end
                    4: if (m_tick) begin
                        m_ticks++;
                        if (m_ticks == CT) begin m_st = 1; m_ticks = 0; end
                    end
                    default: m_st = 0;
                endcase
                if (m_acc && !m_byp) begin
                    if (mq.size() == QD && !m_pop) m_drop = 1;
                    else mq.push_back(m_cmd);
                end
            end
        end
    end

    logic [3:0] e_mv, e_lamp;
    always @(negedge sys_clk) begin
        e_mv = (m_st == 1 || m_st == 4) ? 4'b0001 :
               (m_st == 3) ? ((m_dir == 2) ? 4'b0100 : 4'b1000) : 4'b0000;
        e_lamp = {e_mv == 4'b0001, m_st == 3 && m_dir == 3, m_st == 3 && m_dir == 2,
                  m_st == 3 && (m_dir == 1 || m_dir == 3)};
        chk("state_moving", {nav_state, moving_state}, {3'(m_st), e_mv});
        chk("lamps", {move_forward_light, move_backward_light, turn_left_light, turn_right_light},
            e_lamp);
        chk("queue", {q_count, q_full, cmd_drop}, {2'(mq.size()), mq.size() == QD, m_drop});
        if (cmd_drop) drops++;
    end

    // ---------------- stimulus ----------------
    task automatic press(input logic [3:0] v);
        @(posedge sys_clk); #2;
        {go_back, turn_left, turn_right, go_straight} = v;
        repeat (2) @(posedge sys_clk); #2;
        {go_back, turn_left, turn_right, go_straight} = 4'b0;
        repeat (2) @(posedge sys_clk);
    endtask

    task automatic wait_state(input logic [2:0] code, input int budget);
        for (int i = 0; i < budget && nav_state != code; i++) @(negedge sys_clk);
        chk("wait_state", nav_state, code);
    endtask

    int d0, r;
    logic [3:0] bv;

    initial begin
        #1 rst = 1'b0;
        power = 1'b1; global_state = 2'b01; detector = 4'b0110;
        @(negedge sys_clk);
        chk("rst_nav", nav_state, 3'd0);
        chk("rst_mv", moving_state, 4'b0000);
        chk("rst_q", q_count, 2'd0);
        @(posedge sys_clk); #2 rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        chk("idle_to_wait", nav_state, 3'd2);

        // bypass left from an empty queue
        press(4'b0100);
        wait_state(3'd3, 10);
        chk("left_mv", moving_state, 4'b0100);
        chk("left_lamp", turn_left_light, 1'b1);
        wait_state(3'd4, 40);
        chk("cool_mv", moving_state, 4'b0001);
        wait_state(3'd1, 40);

        // queue two, drop the third
        press(4'b0010);
        press(4'b0001);
        @(negedge sys_clk);
        chk("q_two", q_count, 2'd2);
        chk("q_full", q_full, 1'b1);
        d0 = drops;
        press(4'b1000);
        @(negedge sys_clk);
        chk("drop_pulse", drops - d0, 1);
        chk("q_still_two", q_count, 2'd2);
        detector = 4'b0001;
        wait_state(3'd3, 10);
        chk("right_mv", moving_state, 4'b1000);
        chk("right_lamp", turn_right_light, 1'b1);
        detector = 4'b0110;
        wait_state(3'd1, 60);
        chk("q_one", q_count, 2'd1);

        // crossroad pops straight; crossroad masked during cooldown
        detector = 4'b0001;
        wait_state(3'd4, 10);
        repeat (3) @(negedge sys_clk);
        chk("cool_masked", nav_state, 3'd4);
        wait_state(3'd2, 30);
        chk("wait_stop", moving_state, 4'b0000);

        // back manoeuvre, queue one more, then disable
        press(4'b1000);
        wait_state(3'd3, 10);
        chk("back_mv", moving_state, 4'b1000);
        chk("back_lamp", move_backward_light, 1'b1);
        detector = 4'b0110;
        press(4'b0100);
        @(negedge sys_clk);
        chk("q_in_turn", q_count, 2'd1);
        @(posedge sys_clk); #2 global_state = 2'b00;
        repeat (2) @(negedge sys_clk);
        chk("dis_nav", nav_state, 3'd0);
        chk("dis_mv", moving_state, 4'b0000);
        chk("dis_q", q_count, 2'd0);
        @(posedge sys_clk); #2 global_state = 2'b10;
        press(4'b0110);
        repeat (3) @(negedge sys_clk);
        chk("multi_btn_nav", nav_state, 3'd2);
        chk("multi_btn_q", q_count, 2'd0);

        // asynchronous reset mid-turn
        press(4'b0010);
        wait_state(3'd3, 10);
        @(posedge sys_clk); #2 rst = 1'b0;
        #1;
        chk("async_nav", nav_state, 3'd0);
        chk("async_mv", moving_state, 4'b0000);
        chk("async_lamp", turn_right_light, 1'b0);
        @(posedge sys_clk); #2 rst = 1'b1;
        wait_state(3'd2, 5);
        chk("post_rst_mv", moving_state, 4'b0000);

        // randomised phase
        for (int c = 0; c < 4000; c++) begin
            @(posedge sys_clk); #2;
            rst = ($urandom_range(0, 799) != 0);
            power = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 5) == 0) begin
                r  = $urandom_range(0, 9);
                bv = (r < 4) ? 4'b0 : (r < 8) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
                {go_back, turn_left, turn_right, go_straight} = bv;
            end
            if ($urandom_range(0, 14) == 0)
                detector = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0110;
            if ($urandom_range(0, 249) == 0) global_state = 2'($urandom);
            else if (global_state inside {2'b00, 2'b11} && $urandom_range(0, 9) == 0)
                global_state = 2'b01;
        end
        @(posedge sys_clk); #2 rst = 1'b1;
        repeat (2) @(negedge sys_clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
